reaction_timer_top: RTL and testbench

Human reaction-time tester for the board top level. After `start`, it waits a pseudo-random delay, lights `led`, and counts milliseconds until `stop`. It shows the result as 4 BCD digits on the multiplexed 7-segment display and in binary on `LED`. It sits directly under the board wrapper, fed by debounced buttons and slide switches.

---
 rtl/reaction_timer_pkg.sv | 47 ++++
 rtl/sseg_mux.sv | 62 ++++++
 rtl/reaction_timer_top.sv | 178 +++++++++++++++++
 tb/tb_reaction_timer_top.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: FSM states, digit
// codes, segment patterns, LFSR seed and the cheat result.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TIMING,
    ST_DONE
  } rt_state_t;

  // Active-low segment patterns, bit7 = dp, bits 6..0 = g..a
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_I     = 8'hF9;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // 5-bit digit codes fed to the display mux: 0..9 are BCD values
  localparam logic [4:0] DIG_H     = 5'd10;
  localparam logic [4:0] DIG_I     = 5'd11;
  localparam logic [4:0] DIG_BLANK = 5'd31;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Result shown when the button is pressed before the light
  localparam logic [15:0] CHEAT_BIN = 16'd9999;
  localparam logic [15:0] CHEAT_BCD = 16'h9999;

  // Increment a 4-digit packed BCD value, wrapping 9999 -> 0000
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_mux.sv
// Four-digit multiplexed 7-segment driver. A free-running refresh counter
// selects one digit at a time (top two bits); outputs are active-low.
module sseg_mux
  import reaction_timer_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] dig0_i,
  input  logic [4:0] dig1_i,
  input  logic [4:0] dig2_i,
  input  logic [4:0] dig3_i,
  output logic [7:0] an_o,
  output logic [7:0] sseg_o
);

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              sel;
  logic [4:0]              code;

  // Refresh counter, cleared asynchronously so digit 0 is shown out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refresh_q <= '0;
    else        refresh_q <= refresh_q + 1'b1;
  end

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];

  // Digit select and anode enable; upper four anodes are never used
  always_comb begin
    code = DIG_BLANK;
    an_o = 8'hFF;
    case (sel)
      2'd0: begin code = dig0_i; an_o = 8'hFE; end
      2'd1: begin code = dig1_i; an_o = 8'hFD; end
      2'd2: begin code = dig2_i; an_o = 8'hFB; end
      default: begin code = dig3_i; an_o = 8'hF7; end
    endcase
  end

  // Digit code to active-low segment pattern
  always_comb begin
    sseg_o = SEG_BLANK;
    case (code)
      5'd0:    sseg_o = 8'hC0;
      5'd1:    sseg_o = 8'hF9;
      5'd2:    sseg_o = 8'hA4;
      5'd3:    sseg_o = 8'hB0;
      5'd4:    sseg_o = 8'h99;
      5'd5:    sseg_o = 8'h92;
      5'd6:    sseg_o = 8'h82;
      5'd7:    sseg_o = 8'hF8;
      5'd8:    sseg_o = 8'h80;
      5'd9:    sseg_o = 8'h90;
      DIG_H:   sseg_o = SEG_H;
      DIG_I:   sseg_o = SEG_I;
      default: sseg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/reaction_timer_top.sv
// Reaction-time tester: random wait, light, then count ms until stop.
// Optional feature macro: RT_CHEAT_DETECT_EN (stop during the wait ends the
// trial with 9999); when undefined, stop during the wait is ignored.
module reaction_timer_top
  import reaction_timer_pkg::*;
#(
  parameter int TICKS_PER_MS = 100_000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int TIMEOUT_MS   = 1000,
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] SW,
  output logic [7:0]  an,
  output logic [7:0]  sseg,
  output logic        led,
  output logic [15:0] LED
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  // [0],[1] synchronizer, [2] previous synchronized value
  logic [2:0]  start_sync_q, stop_sync_q, clear_sync_q;
  logic        start_edge_q, stop_edge_q, clear_edge_q;
  logic        start_rise;

  logic [15:0] lfsr_q, lfsr_d;
  rt_state_t   state_q;
  logic [PW-1:0] presc_q;
  logic        tick;
  logic [15:0] delay_q;
  logic [15:0] bin_q;
  logic [15:0] bcd_q, bcd_d;
  logic        led_q;
  logic [4:0]  dig0, dig1, dig2, dig3;

  assign start_rise = start_sync_q[1] & ~start_sync_q[2];

  // Input synchronizers and registered rising-edge pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      clear_sync_q <= '0;
      start_edge_q <= 1'b0;
      stop_edge_q  <= 1'b0;
      clear_edge_q <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start};
      stop_sync_q  <= {stop_sync_q[1:0], stop};
      clear_sync_q <= {clear_sync_q[1:0], clear};
      start_edge_q <= start_rise;
      stop_edge_q  <= stop_sync_q[1] & ~stop_sync_q[2];
      clear_edge_q <= clear_sync_q[1] & ~clear_sync_q[2];
    end
  end

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};

  // LFSR: seeded one cycle ahead of the start pulse so the FSM loads the
  // delay from the freshly seeded value; free-runs otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            lfsr_q <= LFSR_SEED;
    else if (start_rise) lfsr_q <= (SW == '0) ? LFSR_SEED : SW;
    else                 lfsr_q <= lfsr_d;
  end

  assign tick  = (presc_q == PW'(TICKS_PER_MS - 1));
  assign bcd_d = bcd_inc(bcd_q);

  // Trial FSM with ms prescaler, wait countdown and result counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      delay_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (clear_edge_q) begin
        state_q <= ST_IDLE;
        led_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            // stop outranks start even though stop has no effect here
            if (!stop_edge_q && start_edge_q) begin
              state_q <= ST_WAIT;
              presc_q <= '0;
              delay_q <= 16'(MIN_DELAY_MS) + {3'b000, lfsr_q[12:0]};
              bin_q   <= '0;
              bcd_q   <= '0;
              led_q   <= 1'b0;
            end
          end
          ST_WAIT: begin
`ifdef RT_CHEAT_DETECT_EN
            if (stop_edge_q) begin
              state_q <= ST_DONE;
              bin_q   <= CHEAT_BIN;
              bcd_q   <= CHEAT_BCD;
              led_q   <= 1'b0;
            end else
`endif
            if (tick) begin
              if (delay_q == 16'd1) begin
                state_q <= ST_TIMING;
                presc_q <= '0;
                led_q   <= 1'b1;
              end else begin
                delay_q <= delay_q - 16'd1;
              end
            end
          end
          ST_TIMING: begin
            // A stop coinciding with a tick freezes the pre-tick count
            if (stop_edge_q) begin
              state_q <= ST_DONE;
              led_q   <= 1'b0;
            end else if (tick) begin
              bin_q <= bin_q + 16'd1;
              bcd_q <= bcd_d;
              if (bin_q == 16'(TIMEOUT_MS - 1)) begin
                state_q <= ST_DONE;
                led_q   <= 1'b0;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Digit codes presented to the display for each state
  always_comb begin
    dig3 = DIG_BLANK;
    dig2 = DIG_BLANK;
    dig1 = DIG_BLANK;
    dig0 = DIG_BLANK;
    case (state_q)
      ST_IDLE: begin
        dig1 = DIG_H;
        dig0 = DIG_I;
      end
      ST_WAIT: ;
      default: begin
        dig3 = {1'b0, bcd_q[15:12]};
        dig2 = {1'b0, bcd_q[11:8]};
        dig1 = {1'b0, bcd_q[7:4]};
        dig0 = {1'b0, bcd_q[3:0]};
      end
    endcase
  end

  sseg_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_sseg_mux (
    .clk   (clk),
    .rst_n (rst),
    .dig0_i(dig0),
    .dig1_i(dig1),
    .dig2_i(dig2),
    .dig3_i(dig3),
    .an_o  (an),
    .sseg_o(sseg)
  );

  assign led = led_q;
  assign LED = bin_q;

endmodule

// File: tb/tb_reaction_timer_top.sv
// Self-checking bench for reaction_timer_top.
module tb_reaction_timer_top;

  localparam int TICKS  = 10;
  localparam int REFB   = 4;
  localparam int MIN_MS = 200;
  localparam int TMO    = 1000;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear;
  logic [15:0] SW;
  logic [7:0]  an, sseg;
  logic        led;
  logic [15:0] LED;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] led_val;
    logic [31:0] segs;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] disp[4];

  always #5 clk = ~clk;

  reaction_timer_top #(
    .TICKS_PER_MS(TICKS),
    .MIN_DELAY_MS(MIN_MS),
    .TIMEOUT_MS  (TMO),
    .REFRESH_BITS(REFB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .clear(clear),
    .SW   (SW),
    .an   (an),
    .sseg (sseg),
    .led  (led),
    .LED  (LED)
  );

  function automatic logic [7:0] seg7(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] exp_segs(input int v);
    return {seg7((v / 1000) % 10), seg7((v / 100) % 10), seg7((v / 10) % 10), seg7(v % 10)};
  endfunction

  function automatic int exp_delay(input logic [15:0] sw);
    logic [15:0] seed;
    seed = (sw == 16'h0000) ? 16'hACE1 : sw;
    return MIN_MS + int'(seed[12:0]);
  endfunction

  // Record which pattern each digit shows over one full refresh period
  task automatic capture_display();
    for (int i = 0; i < 4; i++) disp[i] = 8'h00;
    repeat (1 << REFB) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (an[i] === 1'b0) disp[i] = sseg;
    end
  endtask

  // Pulse start with the given switches; optionally pulse stop at cycle
  // stop_at; returns the number of clocks until led is seen high (or limit)
  task automatic start_trial(input logic [15:0] sw, input int stop_at, input int limit,
                             output int n);
    @(negedge clk);
    SW    = sw;
    start = 1'b1;
    n     = 0;
    while (n < limit) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 3) start = 1'b0;
      if (stop_at != 0 && n == stop_at) stop = 1'b1;
      if (stop_at != 0 && n == stop_at + 3) stop = 1'b0;
      if (led === 1'b1) break;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; SW = 16'h0000;
    #100;
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", led); end
    checks++; if (LED !== 16'h0000) begin errors++; $display("FAIL reset_LED: got %h expected 0000", LED); end
    checks++; if (an !== 8'hFE) begin errors++; $display("FAIL reset_an: got %h expected fe", an); end
    checks++; if (sseg !== 8'hF9) begin errors++; $display("FAIL reset_sseg: got %h expected f9", sseg); end
    @(negedge clk);
    rst = 1'b1;
    capture_display();
    checks++; if (disp[3] !== 8'hFF) begin errors++; $display("FAIL idle_dig3: got %h expected ff", disp[3]); end
    checks++; if (disp[2] !== 8'hFF) begin errors++; $display("FAIL idle_dig2: got %h expected ff", disp[2]); end
    checks++; if (disp[1] !== 8'h89) begin errors++; $display("FAIL idle_dig1: got %h expected 89", disp[1]); end
    checks++; if (disp[0] !== 8'hF9) begin errors++; $display("FAIL idle_dig0: got %h expected f9", disp[0]); end
  endtask

  task automatic test_normal();
    int   n, d, wait_n;
    exp_t e;
    d = exp_delay(16'h0001);
    start_trial(16'h0001, 0, 4 + TICKS * d + 20, n);
    checks++;
    if (n !== 4 + TICKS * d) begin errors++; $display("FAIL normal_led_rise: got %0d clocks expected %0d", n, 4 + TICKS * d); end
    // stop is acted on 4 clocks after it is driven; ticks land every TICKS
    // clocks after entry, and one landing on the stop edge is not counted
    wait_n = 2506;
    repeat (wait_n) @(posedge clk);
    @(negedge clk);
    stop = 1'b1;
    exp_q.push_back('{name: "normal", led_val: 16'((wait_n + 3) / TICKS), segs: exp_segs((wait_n + 3) / TICKS)});
    repeat (3) @(negedge clk);
    stop = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL normal_led_off: got %b expected 0", led); end
    e = exp_q.pop_front();
    capture_display();
    checks++;
    if (LED !== e.led_val) begin errors++; $display("FAIL %s_LED: got %0d expected %0d", e.name, LED, e.led_val); end
    checks++;
    if ({disp[3], disp[2], disp[1], disp[0]} !== e.segs) begin
      errors++; $display("FAIL %s_display: got %h expected %h", e.name, {disp[3], disp[2], disp[1], disp[0]}, e.segs);
    end
  endtask

  task automatic test_timeout();
    int   n, m;
    exp_t e;
    start_trial(16'h2000, 0, 4 + TICKS * MIN_MS + 20, n);
    checks++;
    if (n !== 4 + TICKS * MIN_MS) begin errors++; $display("FAIL timeout_led_rise: got %0d clocks expected %0d", n, 4 + TICKS * MIN_MS); end
    exp_q.push_back('{name: "timeout", led_val: 16'(TMO), segs: exp_segs(TMO)});
    m = 0;
    while (led === 1'b1 && m < TMO * TICKS + 50) begin
      @(posedge clk);
      m++;
      @(negedge clk);
    end
    checks++;
    if (m !== TMO * TICKS) begin errors++; $display("FAIL timeout_duration: got %0d clocks expected %0d", m, TMO * TICKS); end
    e = exp_q.pop_front();
    capture_display();
    checks++;
    if (LED !== e.led_val) begin errors++; $display("FAIL %s_LED: got %0d expected %0d", e.name, LED, e.led_val); end
    checks++;
    if ({disp[3], disp[2], disp[1], disp[0]} !== e.segs) begin
      errors++; $display("FAIL %s_display: got %h expected %h", e.name, {disp[3], disp[2], disp[1], disp[0]}, e.segs);
    end
  endtask

  task automatic test_done_priority();
    exp_t e;
    exp_q.push_back('{name: "priority", led_val: 16'(TMO), segs: exp_segs(TMO)});
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL priority_led: got %b expected 0", led); end
    e = exp_q.pop_front();
    capture_display();
    checks++;
    if (LED !== e.led_val) begin errors++; $display("FAIL %s_LED: got %0d expected %0d", e.name, LED, e.led_val); end
    checks++;
    if ({disp[3], disp[2], disp[1], disp[0]} !== e.segs) begin
      errors++; $display("FAIL %s_display: got %h expected %h", e.name, {disp[3], disp[2], disp[1], disp[0]}, e.segs);
    end
  endtask

  task automatic test_cheat();
    int d, n;
`ifdef RT_CHEAT_DETECT_EN
    exp_t e;
    start_trial(16'h0000, 100 * TICKS, 100 * TICKS + 12, n);
    exp_q.push_back('{name: "cheat", led_val: 16'h270F, segs: exp_segs(9999)});
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL cheat_led: got %b expected 0", led); end
    e = exp_q.pop_front();
    capture_display();
    checks++;
    if (LED !== e.led_val) begin errors++; $display("FAIL %s_LED: got %h expected %h", e.name, LED, e.led_val); end
    checks++;
    if ({disp[3], disp[2], disp[1], disp[0]} !== e.segs) begin
      errors++; $display("FAIL %s_display: got %h expected %h", e.name, {disp[3], disp[2], disp[1], disp[0]}, e.segs);
    end
    d = 0;
`else
    d = exp_delay(16'h0000);
    start_trial(16'h0000, 100 * TICKS, 4 + TICKS * d + 20, n);
    checks++;
    if (n !== 4 + TICKS * d) begin errors++; $display("FAIL nocheat_led_rise: got %0d clocks expected %0d", n, 4 + TICKS * d); end
`endif
  endtask

  task automatic test_clear_timing();
    int n;
    if (led !== 1'b1) start_trial(16'h0001, 0, 4 + TICKS * exp_delay(16'h0001) + 20, n);
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL clear_pre_led: got %b expected 1", led); end
    @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL clear_led: got %b expected 0", led); end
    capture_display();
    checks++;
    if ({disp[3], disp[2], disp[1], disp[0]} !== {8'hFF, 8'hFF, 8'h89, 8'hF9}) begin
      errors++; $display("FAIL clear_display: got %h expected ffff89f9", {disp[3], disp[2], disp[1], disp[0]});
    end
  endtask

  task automatic test_async_reset();
    int n;
    start_trial(16'h0001, 0, 4 + TICKS * exp_delay(16'h0001) + 20, n);
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL areset_pre_led: got %b expected 1", led); end
    repeat (303) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL areset_led: got %b expected 0", led); end
    checks++; if (LED !== 16'h0000) begin errors++; $display("FAIL areset_LED: got %h expected 0000", LED); end
    checks++; if (an !== 8'hFE) begin errors++; $display("FAIL areset_an: got %h expected fe", an); end
    checks++; if (sseg !== 8'hF9) begin errors++; $display("FAIL areset_sseg: got %h expected f9", sseg); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_done_priority();
    test_cheat();
    test_clear_timing();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
